// File: rtl/sensor_alarm_pkg.sv
// Shared state encoding and width helpers for the sensor alarm controller.
package sensor_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_ALARM   = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter wide enough to hold its terminal value; never narrower than one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal > 0) ? $clog2(terminal + 1) : 1;
  endfunction

endpackage

// File: rtl/sensor_prio_enc.sv
// Fixed-priority find-first-set: the lowest-index asserted sensor wins.
module sensor_prio_enc
  import sensor_alarm_pkg::*;
#(
  parameter int N_CH = 3
)(
  input  logic [N_CH-1:0]           i_sensor,
  output logic                      o_valid,
  output logic [id_width(N_CH)-1:0] o_idx
);

  localparam int ID_W = id_width(N_CH);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_sensor[i]) begin
        o_valid = 1'b1;
        o_idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/sensor_alarm_ctrl.sv
// N-channel debounced alarm controller: qualify a stable winning sensor, drive its
// alarm for ALARM_LEN cycles (ack ends it early), then blank for HOLDOFF cycles.
module sensor_alarm_ctrl
  import sensor_alarm_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int DEBOUNCE  = 7,
  parameter int ALARM_LEN = 31,
  parameter int HOLDOFF   = 4
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [N_CH-1:0]           sensor,
  input  logic                      ack,
  output logic [N_CH-1:0]           alarm,
  output logic                      alarm_active,
  output logic [id_width(N_CH)-1:0] alarm_id,
  output logic                      event_pulse
);

  localparam int ID_W = id_width(N_CH);
  localparam int QW   = cnt_width(DEBOUNCE);
  localparam int AW   = cnt_width(ALARM_LEN);
  localparam int HW   = cnt_width(HOLDOFF);

  localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE - 1);
  localparam logic [AW-1:0] A_LAST = AW'(ALARM_LEN);
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF);

  logic            w_valid;
  logic [ID_W-1:0] w_idx;

  state_t          r_state;
  logic [ID_W-1:0] r_cand;
  logic [QW-1:0]   r_qcnt;
  logic [AW-1:0]   r_acnt;
  logic [HW-1:0]   r_hcnt;
  logic [N_CH-1:0] r_alarm;
  logic            r_active;
  logic [ID_W-1:0] r_id;
  logic            r_event;

  // Saturating increments keep every counter pinned at its terminal value.
  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] c);
    return (c >= Q_LAST) ? c : c + QW'(1);
  endfunction

  function automatic logic [AW-1:0] a_inc(input logic [AW-1:0] c);
    return (c >= A_LAST) ? c : c + AW'(1);
  endfunction

  function automatic logic [HW-1:0] h_inc(input logic [HW-1:0] c);
    return (c >= H_LAST) ? c : c + HW'(1);
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [ID_W-1:0] idx);
    return N_CH'(1) << idx;
  endfunction

  sensor_prio_enc #(
    .N_CH (N_CH)
  ) u_prio (
    .i_sensor (sensor),
    .o_valid  (w_valid),
    .o_idx    (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cand   <= '0;
      r_qcnt   <= '0;
      r_acnt   <= '0;
      r_hcnt   <= '0;
      r_alarm  <= '0;
      r_active <= 1'b0;
      r_id     <= '0;
      r_event  <= 1'b0;
    end else if (ena) begin
      r_event <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_cand <= w_idx;
            if (DEBOUNCE == 1) begin
              r_state  <= ST_ALARM;
              r_qcnt   <= '0;
              r_acnt   <= AW'(1);
              r_alarm  <= onehot(w_idx);
              r_active <= 1'b1;
              r_id     <= w_idx;
              r_event  <= 1'b1;
            end else begin
              r_state <= ST_QUALIFY;
              r_qcnt  <= QW'(1);
            end
          end
        end

        ST_QUALIFY: begin
          if (!w_valid) begin
            r_state <= ST_IDLE;
            r_qcnt  <= '0;
          end else if (w_idx != r_cand) begin
            r_cand <= w_idx;
            r_qcnt <= QW'(1);
          end else if (r_qcnt >= Q_LAST) begin
            r_state  <= ST_ALARM;
            r_qcnt   <= '0;
            r_acnt   <= AW'(1);
            r_alarm  <= onehot(r_cand);
            r_active <= 1'b1;
            r_id     <= r_cand;
            r_event  <= 1'b1;
          end else begin
            r_qcnt <= q_inc(r_qcnt);
          end
        end

        ST_ALARM: begin
          // ack on the last cycle is indistinguishable from natural expiry.
          if (ack || (r_acnt >= A_LAST)) begin
            r_acnt   <= '0;
            r_alarm  <= '0;
            r_active <= 1'b0;
            r_id     <= '0;
            if (HOLDOFF == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_HOLD;
              r_hcnt  <= HW'(1);
            end
          end else begin
            r_acnt <= a_inc(r_acnt);
          end
        end

        ST_HOLD: begin
          if (r_hcnt >= H_LAST) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
          end else begin
            r_hcnt <= h_inc(r_hcnt);
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_qcnt   <= '0;
          r_acnt   <= '0;
          r_hcnt   <= '0;
          r_alarm  <= '0;
          r_active <= 1'b0;
          r_id     <= '0;
        end
      endcase
    end
  end

  assign alarm        = r_alarm;
  assign alarm_active = r_active;
  assign alarm_id     = r_id;
  assign event_pulse  = r_event;

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Table-driven bench for sensor_alarm_ctrl: default build plus an
// 8-channel, single-sample, no-holdoff build sharing one clock.
module tb_sensor_alarm_ctrl;

  typedef struct {
    logic        sel;
    logic        rst;
    logic        ena;
    logic [7:0]  sensor;
    logic        ack;
    int          reps;
    logic [7:0]  alarm;
    logic        active;
    logic [2:0]  id;
    logic        pulse;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_ena = 1'b1, a_ack = 1'b0;
  logic [2:0] a_sensor = '0;
  logic [2:0] a_alarm;
  logic       a_active, a_pulse;
  logic [1:0] a_id;

  logic       b_rst = 1'b1, b_ena = 1'b1, b_ack = 1'b0;
  logic [7:0] b_sensor = '0;
  logic [7:0] b_alarm;
  logic       b_active, b_pulse;
  logic [2:0] b_id;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  sensor_alarm_ctrl #(
    .N_CH(3), .DEBOUNCE(7), .ALARM_LEN(31), .HOLDOFF(4)
  ) u_dut_a (
    .clk(clk), .rst(a_rst), .ena(a_ena), .sensor(a_sensor), .ack(a_ack),
    .alarm(a_alarm), .alarm_active(a_active), .alarm_id(a_id), .event_pulse(a_pulse)
  );

  sensor_alarm_ctrl #(
    .N_CH(8), .DEBOUNCE(1), .ALARM_LEN(31), .HOLDOFF(0)
  ) u_dut_b (
    .clk(clk), .rst(b_rst), .ena(b_ena), .sensor(b_sensor), .ack(b_ack),
    .alarm(b_alarm), .alarm_active(b_active), .alarm_id(b_id), .event_pulse(b_pulse)
  );

  function automatic void add(input logic sel, input logic rst, input logic ena,
                              input logic [7:0] s, input logic ack, input int reps,
                              input logic [7:0] al, input logic act, input logic [2:0] id,
                              input logic p, input string nm);
    vec_t v;
    v.sel = sel; v.rst = rst; v.ena = ena; v.sensor = s; v.ack = ack; v.reps = reps;
    v.alarm = al; v.active = act; v.id = id; v.pulse = p; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input string field, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, field, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t v);
    vec_t e;
    logic [7:0] g_alarm, g_id;
    logic       g_active, g_pulse;
    if (!v.sel) begin
      a_rst = v.rst; a_ena = v.ena; a_sensor = v.sensor[2:0]; a_ack = v.ack;
    end else begin
      b_rst = v.rst; b_ena = v.ena; b_sensor = v.sensor; b_ack = v.ack;
    end
    exp_q.push_back(v);
    repeat (v.reps) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (!e.sel) begin
      g_alarm = {5'b0, a_alarm}; g_active = a_active; g_id = {6'b0, a_id}; g_pulse = a_pulse;
    end else begin
      g_alarm = b_alarm; g_active = b_active; g_id = {5'b0, b_id}; g_pulse = b_pulse;
    end
    check(e.name, "alarm",  g_alarm,        e.alarm);
    check(e.name, "active", {7'b0, g_active}, {7'b0, e.active});
    check(e.name, "id",     g_id,           {5'b0, e.id});
    check(e.name, "pulse",  {7'b0, g_pulse}, {7'b0, e.pulse});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Default build: basic fire, full length, HOLD blanking, re-fire, ack at cycle 10
    add(0,1,1,8'h00,0, 2,8'h00,0,0,0,"reset");
    add(0,0,1,8'h02,0, 6,8'h00,0,0,0,"t1_qual6");
    add(0,0,1,8'h02,0, 1,8'h02,1,1,1,"t1_fire");
    add(0,0,1,8'h02,0, 1,8'h02,1,1,0,"t1_pulse_drop");
    add(0,0,1,8'h02,0,28,8'h02,1,1,0,"t1_cyc30");
    add(0,0,1,8'h02,0, 1,8'h02,1,1,0,"t1_cyc31");
    add(0,0,1,8'h02,0, 1,8'h00,0,0,0,"t1_expire");
    add(0,0,1,8'h02,0,10,8'h00,0,0,0,"hold_no_count");
    add(0,0,1,8'h02,0, 1,8'h02,1,1,1,"refire");
    add(0,0,1,8'h02,0, 9,8'h02,1,1,0,"ack_cyc10");
    add(0,0,1,8'h00,1, 1,8'h00,0,0,0,"ack_stop");
    add(0,0,1,8'h07,0, 4,8'h00,0,0,0,"ack_hold");
    add(0,0,1,8'h00,0, 1,8'h00,0,0,0,"ack_idle");
    // Broken streak never fires
    add(0,0,1,8'h01,0, 6,8'h00,0,0,0,"t2_run1");
    add(0,0,1,8'h00,0, 1,8'h00,0,0,0,"t2_gap");
    add(0,0,1,8'h01,0, 6,8'h00,0,0,0,"t2_run2");
    add(0,0,1,8'h00,0, 1,8'h00,0,0,0,"t2_idle");
    // Candidate switch restarts the streak on the higher-priority channel
    add(0,0,1,8'h04,0, 4,8'h00,0,0,0,"t3_ch2");
    add(0,0,1,8'h05,0, 6,8'h00,0,0,0,"t3_switch");
    add(0,0,1,8'h05,0, 1,8'h01,1,0,1,"t3_fire");
    // Clock-enable freeze mid-alarm
    add(0,0,1,8'h00,0, 4,8'h01,1,0,0,"ena_pre");
    add(0,0,0,8'h00,0,20,8'h01,1,0,0,"ena_frozen");
    add(0,0,1,8'h00,0,25,8'h01,1,0,0,"ena_cyc30");
    add(0,0,1,8'h00,0, 1,8'h01,1,0,0,"ena_cyc31");
    add(0,0,1,8'h00,0, 1,8'h00,0,0,0,"ena_expire");
    add(0,0,1,8'h00,0, 4,8'h00,0,0,0,"ena_hold");
    // Pulse holds with ena low; reset wins over ena low
    add(0,0,1,8'h01,0, 6,8'h00,0,0,0,"r_qual");
    add(0,0,1,8'h01,0, 1,8'h01,1,0,1,"r_fire");
    add(0,0,0,8'h01,0, 2,8'h01,1,0,1,"r_pulse_hold");
    add(0,1,0,8'h01,0, 1,8'h00,0,0,0,"r_rst_noena");
    add(0,0,1,8'h01,0, 6,8'h00,0,0,0,"r_requal");
    add(0,0,1,8'h01,0, 1,8'h01,1,0,1,"r_refire");
    add(0,1,1,8'h00,0, 1,8'h00,0,0,0,"r_end");
    // 8 channels, DEBOUNCE=1, HOLDOFF=0
    add(1,1,1,8'h00,0, 2,8'h00,0,0,0,"b_reset");
    add(1,0,1,8'hA0,0, 1,8'h20,1,5,1,"b_fire");
    add(1,0,1,8'h00,0,30,8'h20,1,5,0,"b_cyc31");
    add(1,0,1,8'h00,0, 1,8'h00,0,0,0,"b_expire");
    add(1,0,1,8'h80,0, 1,8'h80,1,7,1,"b_direct_idle");
    add(1,0,1,8'h80,1, 1,8'h00,0,0,0,"b_ack");
    add(1,0,1,8'h81,0, 1,8'h01,1,0,1,"b_fire0");
    add(1,1,0,8'h81,0, 1,8'h00,0,0,0,"b_rst");
    add(1,0,1,8'h00,0, 1,8'h00,0,0,0,"b_idle");

    #1;
    foreach (vecs[i]) run(vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
